adder_n: RTL and testbench

ADDER_N -- requirements
Module: adder_n

---
 rtl/adder_n_pkg.sv | 12 +
 rtl/adder_n_cla4.sv | 44 ++++
 rtl/adder_n.sv | 83 ++++++++
 tb/tb_adder_n.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/adder_n_pkg.sv
// Shared constants and helpers for the adder_n slice-chained adder.
package adder_n_pkg;

   localparam int ADDER_N_WIDTH_DEF = 17;
   localparam int SLICE_W           = 4;

   // Number of lookahead slices needed to cover w bits (last one may be partial).
   function automatic int num_slices(input int w);
      return (w + SLICE_W - 1) / SLICE_W;
   endfunction

endpackage

// File: rtl/adder_n_cla4.sv
// Carry-lookahead slice of up to 4 bits; every carry is a flat sum-of-products of g/p/cin.
module adder_n_cla4
   import adder_n_pkg::*;
#(
   parameter int SW = SLICE_W
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout,
   output logic          cmsb
);

   logic [SW-1:0] g, p;
   logic [SW:0]   c;
   logic          allp, term;

   assign g = a & b;
   assign p = a ^ b;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built without reference to c[i]
   always_comb begin
      c    = '0;
      allp = 1'b0;
      term = 1'b0;
      c[0] = cin;
      for (int i = 0; i < SW; i++) begin
         allp = cin;
         for (int j = 0; j <= i; j++) allp = allp & p[j];
         c[i+1] = allp;
         for (int k = 0; k <= i; k++) begin
            term = g[k];
            for (int j = k + 1; j <= i; j++) term = term & p[j];
            c[i+1] = c[i+1] | term;
         end
      end
   end

   assign sum  = p ^ c[SW-1:0];
   assign cout = c[SW];
   assign cmsb = c[SW-1];

endmodule

// File: rtl/adder_n.sv
// WIDTH-bit adder built from chained lookahead slices, optional output register.
// Define ADDER_N_OVF_EN to add the signed-overflow output ovf.
module adder_n
   import adder_n_pkg::*;
#(
   parameter int WIDTH   = ADDER_N_WIDTH_DEF,
   parameter int REG_OUT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDER_N_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int NS = num_slices(WIDTH);

   logic [WIDTH-1:0] s_comb;
   logic [NS:0]      c;
   logic [NS-1:0]    cm;
   logic             unused_sink;

   assign c[0] = cin;

   for (genvar s = 0; s < NS; s++) begin : g_slice
      localparam int LO = s * SLICE_W;
      localparam int SW = (WIDTH - LO < SLICE_W) ? WIDTH - LO : SLICE_W;
      adder_n_cla4 #(.SW(SW)) u_cla (
         .a    (a[LO +: SW]),
         .b    (b[LO +: SW]),
         .cin  (c[s]),
         .sum  (s_comb[LO +: SW]),
         .cout (c[s+1]),
         .cmsb (cm[s])
      );
   end

   // Only the top slice's MSB carry matters; clk/rst_n are idle in the combinational build.
   assign unused_sink = ^{cm, clk, rst_n};

`ifdef ADDER_N_OVF_EN
   logic ovf_comb;
   assign ovf_comb = c[NS] ^ cm[NS-1];
`endif

   if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef ADDER_N_OVF_EN
            ovf       <= 1'b0;
`endif
         end else begin
            out_valid <= in_valid;
            // Results only load on valid so idle/undefined operands never disturb them.
            if (in_valid) begin
               sum  <= s_comb;
               cout <= c[NS];
`ifdef ADDER_N_OVF_EN
               ovf  <= ovf_comb;
`endif
            end
         end
      end
   end else begin : g_comb
      assign out_valid = in_valid;
      assign sum       = s_comb;
      assign cout      = c[NS];
`ifdef ADDER_N_OVF_EN
      assign ovf       = ovf_comb;
`endif
   end

endmodule

// File: tb/tb_adder_n.sv
// Self-checking bench for adder_n (WIDTH=17, REG_OUT=1): arithmetic model plus literal checks.
module tb_adder_n;
   localparam int W = 17;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         out_valid, cout;
   logic [W-1:0] sum;
`ifdef ADDER_N_OVF_EN
   logic         ovf;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   adder_n #(.WIDTH(W), .REG_OUT(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .sum(sum), .cout(cout)
`ifdef ADDER_N_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Model: plain integer arithmetic on what the spec says the registered outputs must hold.
   logic         m_vld, m_cout, m_ovf;
   logic [W-1:0] m_sum;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vld = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else begin
         m_vld = in_valid;
         if (in_valid) begin
            longint ua, ub, sa, sb, tot, stot;
            ua   = longint'(a);
            ub   = longint'(b);
            tot  = ua + ub + longint'(cin);
            m_sum  = tot[W-1:0];
            m_cout = tot[W];
            sa   = a[W-1] ? ua - (64'sd1 <<< W) : ua;
            sb   = b[W-1] ? ub - (64'sd1 <<< W) : ub;
            stot = sa + sb + longint'(cin);
            m_ovf = (stot > (64'sd1 <<< (W-1)) - 1) || (stot < -(64'sd1 <<< (W-1)));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model out_valid", 64'(out_valid), 64'(m_vld));
         chk("model sum", 64'(sum), 64'(m_sum));
         chk("model cout", 64'(cout), 64'(m_cout));
`ifdef ADDER_N_OVF_EN
         chk("model ovf", 64'(ovf), 64'(m_ovf));
`endif
      end
   end

   // Apply one operand set after a falling edge; return after the next falling edge.
   task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
      in_valid = v; a = av; b = bv; cin = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset sum", 64'(sum), 64'd0);
      chk("reset cout", 64'(cout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 17'h0, 17'h0, 1'b0);
      chk("zero sum", 64'(sum), 64'd0);
      chk("zero valid", 64'(out_valid), 64'd1);

      step(1'b1, 17'h1FFFF, 17'h0, 1'b1);
      chk("wrap sum", 64'(sum), 64'd0);
      chk("wrap cout", 64'(cout), 64'd1);
`ifdef ADDER_N_OVF_EN
      chk("wrap ovf", 64'(ovf), 64'd0);
`endif

      step(1'b1, 17'h0FFFF, 17'h00001, 1'b0);
      chk("posmax sum", 64'(sum), 64'h10000);
      chk("posmax cout", 64'(cout), 64'd0);
`ifdef ADDER_N_OVF_EN
      chk("posmax ovf", 64'(ovf), 64'd1);
`endif

      step(1'b1, 17'h1FFFF, 17'h1FFFF, 1'b1);
      chk("allones sum", 64'(sum), 64'h1FFFF);
      chk("allones cout", 64'(cout), 64'd1);

      step(1'b1, 17'd1, 17'd10, 1'b0);
      chk("b2b sum0", 64'(sum), 64'd11);
      step(1'b1, 17'd2, 17'd10, 1'b0);
      chk("b2b sum1", 64'(sum), 64'd12);
      step(1'b1, 17'd3, 17'd10, 1'b0);
      chk("b2b sum2", 64'(sum), 64'd13);
      step(1'b0, 17'd7, 17'd7, 1'b1);
      chk("idle valid", 64'(out_valid), 64'd0);
      chk("idle hold", 64'(sum), 64'd13);

      // Undefined operands while idle must not reach the registers.
      step(1'b0, 'x, 'x, 1'bx);
      chk("x hold sum", 64'(sum), 64'd13);
      chk("x hold cout", 64'(cout), 64'd0);

      step(1'b1, 17'h12345, 17'h0F0F0, 1'b1);
      chk("pre-rst valid", 64'(out_valid), 64'd1);
      in_valid = 1'b1; a = 17'h1; b = 17'h1; cin = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async rst valid", 64'(out_valid), 64'd0);
      chk("async rst sum", 64'(sum), 64'd0);
      chk("async rst cout", 64'(cout), 64'd0);
      #1 rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      step(1'b0, 17'h0, 17'h0, 1'b0);
      chk("post-rst idle", 64'(out_valid), 64'd0);
      step(1'b1, 17'd100, 17'd23, 1'b1);
      chk("post-rst first", 64'(sum), 64'd124);

      for (int i = 0; i < 10000; i++)
         step(($urandom_range(0, 7) != 0), W'($urandom), W'($urandom), 1'($urandom));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
